aes_ctr_seq: RTL



---
 rtl/aes_ctr_pkg.sv | 24 ++
 rtl/aes_ctr_seq_if.sv | 49 ++++
 rtl/aes_ctr_inc.sv | 17 +
 rtl/aes_ctr_seq.sv | 133 +++++++++++++
 4 files changed

// File: rtl/aes_ctr_pkg.sv
// rtl/aes_ctr_pkg.sv - shared widths, types and FSM states of the AES-CTR job sequencer
package aes_ctr_pkg;

  localparam int BLK_W   = 128;
  localparam int NBLK_W  = 16;
  localparam int INC_W   = 32;
  localparam int NO_KEYS = 3;

  typedef logic [1:0]       key_sel_t;
  typedef logic [BLK_W-1:0] blk_t;

  // First key slot number that does not exist
  localparam key_sel_t KEY_LIMIT = key_sel_t'(NO_KEYS);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    XOR,
    OUT,
    FIN
  } ctr_state_e;

endpackage

// File: rtl/aes_ctr_seq_if.sv
// rtl/aes_ctr_seq_if.sv - job, AES-core and plaintext/ciphertext stream signals of the CTR sequencer
interface aes_ctr_seq_if;
  import aes_ctr_pkg::*;

  logic              start;
  key_sel_t          key_sel;
  blk_t              ctr_init;
  logic [NBLK_W-1:0] nblk;
  logic              busy;
  logic              done;
  logic              err;
  logic              core_req;
  logic              core_ack;
  key_sel_t          core_key_sel;
  blk_t              core_blk;
  logic              core_done;
  blk_t              core_res;
  blk_t              pt_tdata;
  logic              pt_tvalid;
  logic              pt_tready;
  blk_t              ct_tdata;
  logic              ct_tvalid;
  logic              ct_tready;

  // Sequencer side
  modport slave (
    input  start, key_sel, ctr_init, nblk,
    output busy, done, err,
    output core_req, core_key_sel, core_blk,
    input  core_ack, core_done, core_res,
    input  pt_tdata, pt_tvalid,
    output pt_tready,
    output ct_tdata, ct_tvalid,
    input  ct_tready
  );

  // Environment side: job controller, AES core and stream endpoints
  modport master (
    output start, key_sel, ctr_init, nblk,
    input  busy, done, err,
    input  core_req, core_key_sel, core_blk,
    output core_ack, core_done, core_res,
    output pt_tdata, pt_tvalid,
    input  pt_tready,
    input  ct_tdata, ct_tvalid,
    output ct_tready
  );

endinterface

// File: rtl/aes_ctr_inc.sv
// rtl/aes_ctr_inc.sv - increments the low INC_W bits of a counter block and flags wrap to zero
module aes_ctr_inc
  import aes_ctr_pkg::*;
(
  input  blk_t i_ctr,
  output blk_t o_ctr,
  output logic o_wrap
);

  logic [INC_W-1:0] w_low;

  // Upper BLK_W-INC_W bits pass through untouched; the low field wraps modulo 2^INC_W
  assign w_low  = i_ctr[INC_W-1:0] + INC_W'(1);
  assign o_ctr  = {i_ctr[BLK_W-1:INC_W], w_low};
  assign o_wrap = (w_low == '0);

endmodule

// File: rtl/aes_ctr_seq.sv
// rtl/aes_ctr_seq.sv - CTR-mode job sequencer for a shared AES core; option macro AES_CTR_SEQ_WRAP_ERR_EN
module aes_ctr_seq
  import aes_ctr_pkg::*;
(
  input  logic         aclk,
  input  logic         aresetn,
  aes_ctr_seq_if.slave io_bus
);

`ifdef AES_CTR_SEQ_WRAP_ERR_EN
  localparam bit WRAP_ERR_EN = 1'b1;
`else
  localparam bit WRAP_ERR_EN = 1'b0;
`endif

  ctr_state_e        r_state;
  ctr_state_e        w_next;
  key_sel_t          r_key;
  blk_t              r_ctr;
  blk_t              r_ks;
  blk_t              r_ct;
  logic [NBLK_W-1:0] r_rem;
  logic              r_err;
  blk_t              w_ctr_next;
  logic              w_wrap;
  logic              w_last;
  logic              w_wrap_stop;
  logic              w_stop;
  logic              w_bad_key;
  logic              w_zero;

  aes_ctr_inc u_inc (
    .i_ctr  (r_ctr),
    .o_ctr  (w_ctr_next),
    .o_wrap (w_wrap)
  );

  assign w_last      = (r_rem == NBLK_W'(1));
  assign w_wrap_stop = WRAP_ERR_EN && w_wrap && !w_last;
  assign w_stop      = w_last || w_wrap_stop;
  assign w_bad_key   = (io_bus.key_sel >= KEY_LIMIT);
  assign w_zero      = (io_bus.nblk == '0);

  assign io_bus.core_blk     = r_ctr;
  assign io_bus.core_key_sel = r_key;
  assign io_bus.ct_tdata     = r_ct;
  assign io_bus.err          = r_err;

  // State register; reset aborts any job without a done pulse
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and the handshake/status outputs decoded from the current state
  always_comb begin
    w_next           = r_state;
    io_bus.busy      = 1'b1;
    io_bus.done      = 1'b0;
    io_bus.core_req  = 1'b0;
    io_bus.pt_tready = 1'b0;
    io_bus.ct_tvalid = 1'b0;
    case (r_state)
      IDLE: begin
        io_bus.busy = 1'b0;
        if (io_bus.start) begin
          w_next = (w_bad_key || w_zero) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        io_bus.core_req = 1'b1;
        if (io_bus.core_ack) w_next = WAIT;
      end
      WAIT: begin
        if (io_bus.core_done) w_next = XOR;
      end
      XOR: begin
        io_bus.pt_tready = 1'b1;
        if (io_bus.pt_tvalid) w_next = OUT;
      end
      OUT: begin
        io_bus.ct_tvalid = 1'b1;
        if (io_bus.ct_tready) w_next = w_stop ? FIN : ISSUE;
      end
      FIN: begin
        io_bus.done = 1'b1;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Job parameters, keystream capture, ciphertext register and per-block counter advance
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_key <= '0;
      r_ctr <= '0;
      r_ks  <= '0;
      r_ct  <= '0;
      r_rem <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.start) begin
            r_key <= io_bus.key_sel;
            r_ctr <= io_bus.ctr_init;
            r_rem <= io_bus.nblk;
            r_err <= w_bad_key;
          end
        end
        WAIT: begin
          if (io_bus.core_done) r_ks <= io_bus.core_res;
        end
        XOR: begin
          if (io_bus.pt_tvalid) r_ct <= io_bus.pt_tdata ^ r_ks;
        end
        OUT: begin
          if (io_bus.ct_tready) begin
            r_rem <= r_rem - NBLK_W'(1);
            r_ctr <= w_ctr_next;
            if (w_wrap_stop) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
